// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the registered N:1 mux/arbiter.
// Provides mode encodings, a constant clog2 and the input-word extension function.
package mux_arb_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Extends the low in_w bits of raw to 64 bits; callers truncate to their output width.
    function automatic logic [63:0] ext_word(input logic [63:0] raw, input int in_w, input bit sign_ext);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 64; b++) begin
            if (b < in_w) begin
                r[b] = raw[b];
            end else if (sign_ext) begin
                r[b] = raw[in_w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_reg_rr_grant.sv
// Combinational round-robin grant: picks the first requester at or after rr_ptr, wrapping.
// The pointer register itself lives in the parent.
module rr_grant
    import mux_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  rr_ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              any_req
);

    // Scan from the farthest position back to rr_ptr so the nearest requester wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (req[SEL_W'((int'(rr_ptr) + k) % NUM_IN)]) begin
                grant   = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N:1 mux with valid/ready on every side; explicit select or round-robin mode.
// Optional macro MUX_ARB_TAG_EN adds out_src carrying the granted channel index.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int IN_W     = 13,
    parameter int WIDTH    = 32,
    parameter int EXT_SIGN = 0,
    parameter int MODE     = 0,
    localparam int SEL_W   = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    input  logic [NUM_IN-1:0]      in_valid,
    output logic [NUM_IN-1:0]      in_ready,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef MUX_ARB_TAG_EN
    ,
    output logic [SEL_W-1:0]       out_src
`endif
);

    logic             load;
    logic             grant_ok;
    logic             transfer;
    logic [SEL_W-1:0] grant;
    logic [IN_W-1:0]  grant_word;
    logic [WIDTH-1:0] grant_ext;

    // The output register may accept a new word when empty or being drained this cycle.
    assign load = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;
            logic [SEL_W-1:0] rr_idx;
            logic             any_req;
            logic             unused_sel;

            assign unused_sel = ^sel;

            rr_grant #(
                .NUM_IN (NUM_IN),
                .SEL_W  (SEL_W)
            ) u_rr_grant (
                .req     (in_valid),
                .rr_ptr  (rr_ptr),
                .grant   (rr_idx),
                .any_req (any_req)
            );

            assign grant    = rr_idx;
            assign grant_ok = any_req;

            // Advance past the winner only when a word actually moves.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr <= '0;
                end else if (transfer) begin
                    rr_ptr <= (int'(rr_idx) == NUM_IN - 1) ? '0 : rr_idx + 1'b1;
                end
            end
        end else begin : g_sel
            assign grant    = sel;
            assign grant_ok = (int'(sel) < NUM_IN);
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        if (load && grant_ok) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign transfer   = load && grant_ok && in_valid[grant];
    assign grant_word = in_data[int'(grant)*IN_W +: IN_W];
    assign grant_ext  = WIDTH'(ext_word(64'(grant_word), IN_W, EXT_SIGN != 0));

    // out_data keeps its last value when the register empties; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= transfer;
            if (transfer) begin
                out_data <= grant_ext;
            end
        end
    end

`ifdef MUX_ARB_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_src <= '0;
        end else if (transfer) begin
            out_src <= grant;
        end
    end
`endif

endmodule
